// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 encryption core.
package aes_pkg;

  typedef logic [0:15][7:0] state_t;
  typedef logic [0:3][31:0] rkey_t;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  state_t state_in,
  input  rkey_t  round_key,
  input  logic   skip_mix,
  output state_t state_out
);

  state_t      sub_s;
  state_t      shift_s;
  state_t      mix_s;
  logic [31:0] col_s;

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // byte substitution
  always_comb begin
    sub_s = '0;
    for (int i = 0; i < 16; i++) begin
      sub_s[i] = sbox(state_in[i]);
    end
  end

  // bytes are column-major, so row r of column c sits at index 4*c + r
  always_comb begin
    shift_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_s[4*c+r] = sub_s[4*((c+r)%4)+r];
      end
    end
  end

  // column mixing
  always_comb begin
    mix_s = '0;
    col_s = 32'h0;
    for (int c = 0; c < 4; c++) begin
      col_s = mix_col({shift_s[4*c], shift_s[4*c+1], shift_s[4*c+2], shift_s[4*c+3]});
      mix_s[4*c]   = col_s[31:24];
      mix_s[4*c+1] = col_s[23:16];
      mix_s[4*c+2] = col_s[15:8];
      mix_s[4*c+3] = col_s[7:0];
    end
  end

  // key addition, with MixColumns bypassed in the last round
  always_comb begin
    if (skip_mix) begin
      state_out = shift_s ^ round_key;
    end else begin
      state_out = mix_s ^ round_key;
    end
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock, round keys fetched by index.
module aes_enc_iter
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     data_in,
  output logic [3:0] key_idx,
  input  rkey_t      round_key,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     data_out,
  output logic       busy
);

  localparam logic [3:0] LAST_KEY = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAST_MIX = 4'(NUM_ROUNDS - 1);

  fsm_t       fsm_r, fsm_s;
  logic [3:0] cnt_r, cnt_s;
  state_t     state_r, state_s;
  state_t     data_out_r, data_out_s;
  state_t     round_out_s;
  logic       skip_mix_s;

  assign skip_mix_s = (fsm_r == FINAL);

  aes_enc_round u_round (
    .state_in  (state_r),
    .round_key (round_key),
    .skip_mix  (skip_mix_s),
    .state_out (round_out_s)
  );

  // next-state and datapath update
  always_comb begin
    fsm_s      = fsm_r;
    cnt_s      = cnt_r;
    state_s    = state_r;
    data_out_s = data_out_r;
    case (fsm_r)
      IDLE: begin
        if (in_valid) begin
          state_s = data_in ^ round_key;
          cnt_s   = 4'd1;
          fsm_s   = ROUND;
        end else begin
          fsm_s = IDLE;
        end
      end
      ROUND: begin
        state_s = round_out_s;
        cnt_s   = cnt_r + 4'd1;
        if (cnt_r == LAST_MIX) begin
          fsm_s = FINAL;
        end else begin
          fsm_s = ROUND;
        end
      end
      FINAL: begin
        state_s    = round_out_s;
        data_out_s = round_out_s;
        cnt_s      = 4'd0;
        fsm_s      = DONE;
      end
      DONE: begin
        if (out_ready) begin
          fsm_s = IDLE;
        end else begin
          fsm_s = DONE;
        end
      end
      default: begin
        fsm_s = IDLE;
        cnt_s = 4'd0;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fsm_r      <= IDLE;
      cnt_r      <= 4'd0;
      state_r    <= '0;
      data_out_r <= '0;
    end else begin
      fsm_r      <= fsm_s;
      cnt_r      <= cnt_s;
      state_r    <= state_s;
      data_out_r <= data_out_s;
    end
  end

  // key index decoded from registered state only, so it is stable for the whole cycle
  always_comb begin
    case (fsm_r)
      IDLE:    key_idx = 4'd0;
      ROUND:   key_idx = cnt_r;
      FINAL:   key_idx = LAST_KEY;
      DONE:    key_idx = 4'd0;
      default: key_idx = 4'd0;
    endcase
  end

  assign in_ready  = (fsm_r == IDLE);
  assign out_valid = (fsm_r == DONE);
  assign busy      = (fsm_r == ROUND) || (fsm_r == FINAL);
  assign data_out  = data_out_r;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed-vector bench for aes_enc_iter using FIPS-197 known-answer blocks.
module tb_aes_enc_iter;
  import aes_pkg::*;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_valid;
  logic       in_ready;
  state_t     data_in;
  logic [3:0] key_idx;
  rkey_t      round_key;
  logic       out_valid;
  logic       out_ready;
  state_t     data_out;
  logic       busy;

  rkey_t rk [0:15];
  int    n_pass;
  int    n_total;

  always #5 clk = ~clk;

  assign round_key = rk[key_idx];

  aes_enc_iter dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // key store contents: standard AES-128 key schedule
  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // offer a block, wait for acceptance, then count cycles until out_valid
  task automatic send_block(input logic [127:0] pt, output int lat, output logic [43:0] kseq);
    int guard;
    data_in  = pt;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    kseq = {40'h0, key_idx};
    tick();
    in_valid = 1'b0;
    lat = 99;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc <= 10) kseq = {kseq[39:0], key_idx};
      if (out_valid) begin
        lat = cyc;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [43:0] kseq;
    logic       saw_ready;
    n_pass = 0;
    n_total = 0;
    n_rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    data_in = '0;
    for (int r = 0; r < 16; r++) rk[r] = '0;

    tick();
    tick();
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_key_idx", 128'(key_idx), 128'd0);
    check_eq("rst_data_out", data_out, 128'd0);
    n_rst = 1'b1;
    check_eq("rst_in_ready", 128'(in_ready), 128'd1);

    for (int i = 0; i < 4; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b0;
    check_eq("idle_toggle_in_ready", 128'(in_ready), 128'd1);
    check_eq("idle_toggle_out_valid", 128'(out_valid), 128'd0);
    check_eq("idle_toggle_busy", 128'(busy), 128'd0);

    // FIPS-197 App. B
    expand_key(KEY_B);
    send_block(PT_B, lat, kseq);
    check_eq("b_latency", 128'(lat), 128'd11);
    check_eq("b_ct", data_out, CT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("b_in_ready_back", 128'(in_ready), 128'd1);
    check_eq("b_out_valid_low", 128'(out_valid), 128'd0);
    check_eq("b_ct_held_idle", data_out, CT_B);

    // FIPS-197 App. C.1, then backpressure in DONE
    expand_key(KEY_C);
    send_block(PT_C, lat, kseq);
    check_eq("c_latency", 128'(lat), 128'd11);
    check_eq("c_key_idx_seq", 128'(kseq), 128'h0123456789a);
    check_eq("c_ct", data_out, CT_C);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_out_valid", 128'(out_valid), 128'd1);
      check_eq("bp_in_ready", 128'(in_ready), 128'd0);
      check_eq("bp_data_out", data_out, CT_C);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_release_in_ready", 128'(in_ready), 128'd1);
    check_eq("bp_release_out_valid", 128'(out_valid), 128'd0);

    // second block offered while the first is in flight
    expand_key(KEY_B);
    data_in = PT_B;
    in_valid = 1'b1;
    tick();
    data_in = PT_C;
    check_eq("busy_in_round", 128'(busy), 128'd1);
    saw_ready = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
    end
    check_eq("busy_no_in_ready", 128'(saw_ready), 128'd0);
    check_eq("busy_first_ct", data_out, CT_B);
    expand_key(KEY_C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send_block(PT_C, lat, kseq);
    check_eq("busy_second_latency", 128'(lat), 128'd11);
    check_eq("busy_second_ct", data_out, CT_C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset at E5 of the App. B block
    expand_key(KEY_B);
    data_in = PT_B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_rst = 1'b0;
    tick();
    check_eq("midrst_in_ready", 128'(in_ready), 128'd1);
    check_eq("midrst_out_valid", 128'(out_valid), 128'd0);
    check_eq("midrst_busy", 128'(busy), 128'd0);
    check_eq("midrst_data_out", data_out, 128'd0);
    n_rst = 1'b1;
    expand_key(KEY_C);
    send_block(PT_C, lat, kseq);
    check_eq("midrst_fresh_latency", 128'(lat), 128'd11);
    check_eq("midrst_fresh_ct", data_out, CT_C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_enc_iter.md
# aes_enc_iter

Iterative AES-128 encryption core, the forward-direction counterpart to the decryption round pipeline. It accepts one 128-bit plaintext block over a valid/ready handshake and applies the initial AddRoundKey plus ten rounds, one round per clock. Round keys are fetched by index from an external key store. The ciphertext is presented on a valid/ready output handshake.

## Interface
- Parameters: none. AES-128 only; `NUM_ROUNDS` = 10 comes from `aes_pkg`.
- `clk` — in — 1 — sole clock, rising edge.
- `n_rst` — in — 1 — reset, synchronous, active-low.
- `in_valid` — in — 1 — `data_in` holds a plaintext block.
- `in_ready` — out — 1 — core is able to accept a block.
- `data_in` — in — [0:15][7:0] — plaintext; byte 0 is FIPS-197 in0, column-major.
- `key_idx` — out — 4 — round-key index requested, 0..10.
- `round_key` — in — [0:3][31:0] — round key for `key_idx`, valid combinationally in the same cycle; word 0 is w[4r].
- `out_valid` — out — 1 — `data_out` holds a ciphertext block.
- `out_ready` — in — 1 — downstream accepts the ciphertext.
- `data_out` — out — [0:15][7:0] — ciphertext, same byte order as `data_in`.
- `busy` — out — 1 — a block is in progress (states ROUND or FINAL).

## Operation
- **Reset** (`n_rst`=0 sampled at an edge):
  - state → IDLE, state register → 0, round counter → 0.
  - `out_valid`=0, `data_out`=0, `busy`=0, `key_idx`=0.
  - `in_ready` is 1 in the first cycle after reset releases.
- **State machine**:
  - **IDLE**
    - `in_ready`=1, `key_idx`=0.
    - On `in_valid`: state_reg ← `data_in` ^ `round_key`, cnt ← 1, go to ROUND.
  - **ROUND** (cnt 1..9)
    - `key_idx`=cnt.
    - state_reg ← AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), `round_key`).
    - cnt increments. After the cnt=9 round, go to FINAL.
  - **FINAL** (cnt=10)
    - `key_idx`=10.
    - Same as ROUND but without MixColumns.
    - Result is written to `data_out`; go to DONE.
  - **DONE**
    - `out_valid`=1, `key_idx`=0.
    - On `out_ready`: go to IDLE.
- **Handshakes**:
  - `in_ready` is 1 only in IDLE. `in_valid` in any other state is ignored; the block stays pending upstream.
  - `data_out` and `out_valid` are held stable while `out_valid`=1 and `out_ready`=0.
  - `out_ready` outside DONE has no effect.
- **Arithmetic**:
  - GF(2^8) with polynomial 0x11B. xtime(b) = {b[6:0],0} ^ (b[7] ? 0x1B : 0).
  - MixColumns matrix is [02 03 01 01] circulant.
  - ShiftRows rotates row r left by r columns.
- **Boundaries**:
  - Reset mid-block aborts the block. No `out_valid` is produced for it.
  - `data_out` keeps its last ciphertext after returning to IDLE, until the next FINAL.

## Timing
- Acceptance edge is E0 (IDLE with `in_valid`=1).
- Edges E1..E9 run rounds 1..9. Edge E10 runs round 10.
- `out_valid` rises in the cycle after E10, i.e. 11 cycles after the cycle `in_valid` was sampled.
- If `out_ready`=1 in the first DONE cycle, `in_ready` returns one cycle later.
- Minimum spacing between block acceptances is 12 cycles.
- `key_idx` is a registered-state decode (glitch-free per cycle). The key store must return `round_key` within the same cycle.

## Structure
- `aes_pkg` holds:
  - typedefs `state_t` ([0:15][7:0]) and `rkey_t` ([0:3][31:0]);
  - `NUM_ROUNDS`=10;
  - the S-box as a function or constant table;
  - an `xtime` function;
  - the FSM enum `{IDLE, ROUND, FINAL, DONE}`.
- Sub-module `aes_enc_round`, purely combinational:
  - inputs: `state_t`, `rkey_t`, `skip_mix`;
  - output: next state;
  - one instance, shared by ROUND and FINAL.
- Top level contains only the FSM, the counter and the state/output registers.

## Test plan
- **FIPS-197 App. B**:
  - key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734;
  - `data_out` = 3925841d02dc09fbdc118597196a0b32;
  - `out_valid` rises exactly 11 cycles after `in_valid` is sampled.
- **FIPS-197 App. C.1**:
  - key 000102…0f, plaintext 00112233445566778899aabbccddeeff;
  - ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a;
  - `key_idx` sequence across E0..E10 is 0,1,…,10.
- **Output backpressure**:
  - hold `out_ready`=0 for 5 cycles in DONE;
  - `data_out` and `out_valid` stay constant and `in_ready`=0;
  - release → IDLE next cycle.
- **Input while busy**:
  - assert `in_valid` with a second block during ROUND;
  - it is not accepted until IDLE, and both ciphertexts are correct and in order.
- **Reset mid-block**:
  - drive `n_rst`=0 at E5 of the App. B vector;
  - next cycle shows IDLE, `out_valid`=0, `busy`=0, `data_out`=0;
  - a fresh App. C.1 block then completes correctly.
- **Reset values**:
  - after reset, all outputs are 0 except `in_ready`=1;
  - toggling `out_ready` in IDLE causes no state change.
